bounce_gen: RTL and testbench

Synthesizable switch-bounce emulator: on command it drives a single-bit output to a target level, overlaid with a programmable number of pseudo-random glitch pulses, then holds the level stable. It drives the noisy-input side of the board's push-button debouncers. Uses are on-chip self-test of the input-conditioning path and lab demos without mechanical switches. Pulse spacing comes from a free-running LFSR, so sequences are repeatable from reset.

---
 rtl/bounce_gen_pkg.sv | 22 ++
 rtl/bounce_lfsr.sv | 32 +++
 rtl/bounce_gen.sv | 143 ++++++++++++++
 tb/tb_bounce_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_gen_pkg.sv
// bounce_gen_pkg: shared types and constants for the switch-bounce emulator
// and for other stimulus generators that reuse its LFSR.
//   state_t      - sequencer states (IDLE, BOUNCE, SETTLE)
//   LFSR_TAPS    - Galois tap mask for x^16+x^14+x^13+x^11+1
//   DEFAULT_SEED - LFSR reset value
//   lfsr_next()  - one right-shift Galois step
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// bounce_lfsr: 16-bit Galois LFSR, free-running while en_i is high.
//   clk_in  - clock
//   rst_in  - asynchronous, active-high reset (loads the seed)
//   en_i    - advance enable
//   state_o - current LFSR value (never zero)
module bounce_lfsr
  import bounce_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en_i,
  output logic [15:0] state_o
);

  // An all-zero state would lock the register, so a zero seed is replaced.
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] state_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= SEED_SAFE;
    end else if (en_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/bounce_gen.sv
// bounce_gen: on start_in drives noisy_out to a target level, overlays a
// programmable number of pseudo-random glitch pulses, then holds the level
// for SETTLE_CYC cycles and pulses done_out.
//   clk_in      - clock
//   rst_in      - asynchronous, active-high reset
//   start_in    - one-cycle request, accepted only in IDLE
//   level_in    - target level, sampled on acceptance
//   bounces_in  - number of glitch pulses, sampled on acceptance
//   gap_mask_in - mask on the LFSR forming each random interval
//   noisy_out   - emulated switch contact
//   busy_out    - high from acceptance until done
//   done_out    - one-cycle completion pulse
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int          MIN_GAP    = 4,
  parameter int          LFSR_W     = 16,
  parameter int          CNT_W      = 20,
  parameter logic [15:0] SEED       = DEFAULT_SEED,
  parameter int          SETTLE_CYC = 2048
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              level_in,
  input  logic [3:0]        bounces_in,
  input  logic [LFSR_W-1:0] gap_mask_in,
  output logic              noisy_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam logic [CNT_W-1:0] SETTLE_LEN = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [LFSR_W-1:0] lfsr;
  logic [CNT_W-1:0]  gap_len;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        rem_q, rem_d;
  logic              target_q, target_d;
  logic              noisy_q, noisy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  bounce_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en_i   (1'b1),
    .state_o(lfsr)
  );

  // CNT_W exceeds LFSR_W, so the sum cannot wrap.
  assign gap_len = CNT_W'(MIN_GAP) + CNT_W'(lfsr & gap_mask_in);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      target_q <= 1'b0;
      noisy_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      target_q <= target_d;
      noisy_q  <= noisy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // cnt_q is loaded with the interval length at the edge that starts the
  // interval; the edge that sees it at 1 ends the interval.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    target_d = target_q;
    noisy_d  = noisy_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          target_d = level_in;
          rem_d    = bounces_in;
          noisy_d  = level_in;
          busy_d   = 1'b1;
          if (bounces_in != 4'd0) begin
            state_d = BOUNCE;
            cnt_d   = gap_len;
          end else begin
            state_d = SETTLE;
            cnt_d   = SETTLE_LEN;
          end
        end
      end
      BOUNCE: begin
        if (cnt_q == CNT_ONE) begin
          noisy_d = ~noisy_q;
          cnt_d   = gap_len;
          // Output currently off-target: this toggle completes a glitch.
          if (noisy_q != target_q) begin
            rem_d = rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              state_d = SETTLE;
              cnt_d   = SETTLE_LEN;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SETTLE: begin
        // Stay here through the done cycle so a start coincident with
        // done_out is ignored.
        if (done_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign noisy_out = noisy_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
module tb_bounce_gen;

  localparam int MIN_GAP = 4;
  localparam int SETTLE  = 2048;
  localparam int LPER    = 65535;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        level_in = 1'b0;
  logic [3:0]  bounces_in = 4'd0;
  logic [15:0] gap_mask_in = 16'h0000;
  logic        noisy_out, busy_out, done_out;

  always #5 clk_in = ~clk_in;

  bounce_gen dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start_in   (start_in),
    .level_in   (level_in),
    .bounces_in (bounces_in),
    .gap_mask_in(gap_mask_in),
    .noisy_out  (noisy_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  int n_chk = 0;
  int n_bad = 0;
  int ec = -1;   // index of the latest clock edge since reset release

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, ec);
    end
  endtask

  // Reference LFSR sequence: value used at edge i after reset release.
  logic [15:0] lfsr_tab [LPER];

  // Reference model: absolute-time schedule of output events.
  int   m_next, m_left, m_done_edge, m_next_ok;
  logic m_noisy, m_busy, m_done;
  int   edge_log[$];
  int   done_log[$];
  logic prev_noisy;

  function automatic int gap_at(input int e);
    return MIN_GAP + int'(lfsr_tab[e % LPER] & gap_mask_in);
  endfunction

  task automatic model_reset();
    ec = -1;
    m_next = -1; m_left = 0; m_done_edge = -1; m_next_ok = 0;
    m_noisy = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    prev_noisy = 1'b0;
    edge_log.delete();
    done_log.delete();
  endtask

  always @(posedge clk_in) begin
    if (!rst_in) begin
      ec++;
      m_done = 1'b0;
      if (m_left > 0 && ec == m_next) begin
        m_noisy = ~m_noisy;
        m_left--;
        if (m_left > 0) m_next = ec + gap_at(ec);
        else m_done_edge = ec + SETTLE;
      end
      if (m_busy && ec == m_done_edge) begin
        m_done = 1'b1;
        m_busy = 1'b0;
        m_next_ok = ec + 2;
      end
      if (start_in && !m_busy && ec >= m_next_ok) begin
        m_noisy = level_in;
        m_busy  = 1'b1;
        m_left  = 2 * int'(bounces_in);
        if (bounces_in != 4'd0) m_next = ec + gap_at(ec);
        else m_done_edge = ec + SETTLE;
      end
    end
  end

  always @(negedge clk_in) begin
    if (!rst_in && ec >= 0) begin
      chk("noisy", {31'd0, noisy_out}, {31'd0, m_noisy});
      chk("busy",  {31'd0, busy_out},  {31'd0, m_busy});
      chk("done",  {31'd0, done_out},  {31'd0, m_done});
      if (noisy_out !== prev_noisy) edge_log.push_back(ec);
      prev_noisy = noisy_out;
      if (done_out) done_log.push_back(ec);
    end
  end

  task automatic do_reset();
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    start_in = 1'b0;
    model_reset();
    #1;
    chk("rst_noisy", {31'd0, noisy_out}, 32'd0);
    chk("rst_busy",  {31'd0, busy_out},  32'd0);
    chk("rst_done",  {31'd0, done_out},  32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("lfsr_seed", {16'd0, dut.u_lfsr.state_q}, 32'h0000ACE1);
  endtask

  task automatic wait_ec(input int e);
    int guard = 0;
    while (ec < e && guard < 20000) begin
      @(negedge clk_in);
      guard++;
    end
    if (ec < e) chk("wait_timeout", ec, e);
  endtask

  task automatic pulse_at(input int e);
    wait_ec(e - 1);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic check_det(input string tag);
    for (int i = 0; i < 5; i++)
      chk({tag, "_edge"}, (i < edge_log.size()) ? edge_log[i] : -1, 4 * i);
    chk({tag, "_nedges"}, edge_log.size(), 5);
    chk({tag, "_ndone"}, done_log.size(), 1);
    chk({tag, "_done_at"}, (done_log.size() > 0) ? done_log[0] : -1, 2064);
  endtask

  task automatic run_random_gaps(output int log_out[$]);
    int bad_iv;
    do_reset();
    gap_mask_in = 16'h000F;
    level_in = 1'b1; bounces_in = 4'd15; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_ec(30 * 19 + SETTLE + 10);
    chk("rnd_nedges", edge_log.size(), 31);
    bad_iv = 0;
    for (int i = 1; i < edge_log.size(); i++) begin
      if (edge_log[i] - edge_log[i-1] < 4 || edge_log[i] - edge_log[i-1] > 19) bad_iv++;
    end
    chk("rnd_interval_range", bad_iv, 0);
    chk("rnd_final_level", {31'd0, noisy_out}, 32'd1);
    chk("rnd_ndone", done_log.size(), 1);
    log_out = edge_log;
  endtask

  initial begin
    int run_a[$];
    int run_b[$];
    int diff;
    logic [15:0] s;

    s = 16'hACE1;
    for (int i = 0; i < LPER; i++) begin
      lfsr_tab[i] = s;
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end

    // Deterministic bounces with ignored starts at edges 3, 2064 and 2065.
    do_reset();
    gap_mask_in = 16'h0000;
    level_in = 1'b1; bounces_in = 4'd2; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    pulse_at(3);
    pulse_at(2064);
    pulse_at(2065);
    wait_ec(2070);
    check_det("det");

    // Zero bounces from idle-low.
    do_reset();
    level_in = 1'b0; bounces_in = 4'd0; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_ec(2052);
    chk("zero_nedges", edge_log.size(), 0);
    chk("zero_ndone", done_log.size(), 1);
    chk("zero_done_at", (done_log.size() > 0) ? done_log[0] : -1, 2048);

    // Random gaps, repeated after re-reset.
    run_random_gaps(run_a);
    run_random_gaps(run_b);
    diff = 0;
    for (int i = 0; i < run_a.size() && i < run_b.size(); i++)
      if (run_a[i] != run_b[i]) diff++;
    chk("rnd_repeat_size", run_b.size(), run_a.size());
    chk("rnd_repeat_diff", diff, 0);

    // Abort at edge 6, then a full deterministic run.
    do_reset();
    gap_mask_in = 16'h0000;
    level_in = 1'b1; bounces_in = 4'd2; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_ec(5);
    chk("abort_pre_busy", {31'd0, busy_out}, 32'd1);
    do_reset();
    level_in = 1'b1; bounces_in = 4'd2; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_ec(2070);
    check_det("abort_rerun");

    // Randomized runs with start noise while busy and mid-run mask changes.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      int guard;
      level_in    = 1'($urandom_range(0, 1));
      bounces_in  = 4'($urandom_range(0, 15));
      gap_mask_in = 16'($urandom) & ((r % 2 == 1) ? 16'h003F : 16'h0007);
      start_in    = 1'b1;
      @(negedge clk_in);
      guard = 0;
      while ((m_busy || ec < m_next_ok) && guard < 6000) begin
        start_in   = ($urandom_range(0, 40) == 0);
        level_in   = 1'($urandom_range(0, 1));
        bounces_in = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 200) == 0) gap_mask_in = 16'($urandom) & 16'h003F;
        @(negedge clk_in);
        guard++;
      end
      start_in = 1'b0;
      chk("rand_run_bound", {31'd0, guard >= 6000}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
